// File: rtl/dac_sample_streamer.sv
// Paced sample feeder for the 10-bit DAC: buffers core samples in a small FIFO and
// releases one to D every div+1 cycles, holding the last code and counting missed ticks.
//
// state | meaning
// IDLE  | stream stopped, tick counter held at 0, D holds last code
// PRIME | waiting for the FIFO to reach half full
// RUN   | pacing ticks pop one sample per period
module dac_sample_streamer #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [9:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    input  logic                     clr_stat,
    output logic [9:0]               D,
    output logic                     d_strobe,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     streaming,
    output logic [7:0]               underflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [9:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [DIV_W-1:0] r_cnt;
    logic [9:0]       r_d;
    logic             r_strobe;
    logic [7:0]       r_uf_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_tick;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_push   = in_valid && !w_full;
    // enable low suppresses a tick in the same cycle the FSM leaves RUN
    assign w_tick   = (r_state == S_RUN) && enable && (r_cnt == '0);
    assign w_pop    = w_tick && !w_empty;

    assign in_ready      = !w_full;
    assign level         = r_level;
    assign D             = r_d;
    assign d_strobe      = r_strobe;
    assign streaming     = (r_state == S_RUN);
    assign underflow_cnt = r_uf_cnt;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next_state = S_PRIME;
            S_PRIME: begin
                if (!enable)
                    w_next_state = S_IDLE;
                else if (r_level >= LW'(DEPTH / 2))
                    w_next_state = S_RUN;
            end
            S_RUN:   if (!enable) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_PRIME: r_cnt <= (w_next_state == S_RUN) ? div : '0;
                S_RUN: begin
                    if (!enable)
                        r_cnt <= '0;
                    else if (r_cnt == '0)
                        r_cnt <= div;
                    else
                        r_cnt <= r_cnt - DIV_W'(1);
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Storage has no reset; pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_d      <= '0;
            r_strobe <= 1'b0;
            r_uf_cnt <= '0;
        end else begin
            r_strobe <= w_pop;
            if (w_pop)
                r_d <= r_mem[r_rd_ptr];
            if (clr_stat)
                r_uf_cnt <= '0;
            else if (w_tick && w_empty && (r_uf_cnt != 8'hFF))
                r_uf_cnt <= r_uf_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_dac_sample_streamer.sv
// Scoreboard bench for dac_sample_streamer: stimulus queues expected codes,
// a negedge monitor pops and compares them whenever d_strobe is seen.
module tb_dac_sample_streamer;
    localparam int DEPTH = 8;
    localparam int DIV_W = 16;

    logic             CLK = 1'b0;
    logic             reset;
    logic [9:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             enable;
    logic [DIV_W-1:0] div;
    logic             clr_stat;
    logic [9:0]       D;
    logic             d_strobe;
    logic [3:0]       level;
    logic             streaming;
    logic [7:0]       underflow_cnt;

    dac_sample_streamer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .enable(enable), .div(div), .clr_stat(clr_stat),
        .D(D), .d_strobe(d_strobe), .level(level), .streaming(streaming),
        .underflow_cnt(underflow_cnt)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         strobe_cnt = 0;
    int         run_start = 0;
    logic       prev_stream = 1'b0;
    logic [9:0] exp_q [$];
    int         st_q [$];
    logic [9:0] exp_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        cycle++;
        if (streaming && !prev_stream) run_start = cycle;
        prev_stream = streaming;
        if (d_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: D=0x%0h with no queued sample, expected no strobe", D);
            end else begin
                exp_d = exp_q.pop_front();
                chk("d_order", int'(D), int'(exp_d));
            end
            st_q.push_back(cycle);
            strobe_cnt++;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic push(input logic [9:0] v);
        int k = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) chk("push_ready_timeout", 0, 1);
        tick();
        exp_q.push_back(v);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk("strobe_wait", (strobe_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_stream_level(input int lv, input int budget);
        int k = 0;
        while (!(streaming && int'(level) == lv) && k < budget) begin
            tick();
            k++;
        end
        chk("stream_level_wait", (streaming && int'(level) == lv) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int acc;
        logic rdy;

        reset = 1'b0; in_data = '0; in_valid = 1'b0; enable = 1'b0;
        div = '0; clr_stat = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_D", int'(D), 0);
        chk("rst_strobe", int'(d_strobe), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_streaming", int'(streaming), 0);
        chk("rst_underflow", int'(underflow_cnt), 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Priming and pacing, div=3
        st_q.delete();
        div = 16'd3;
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) push(10'(i));
        chk("prime_not_yet_run", int'(streaming), 0);
        chk("prime_level4", int'(level), 4);
        push(10'd5);
        chk("prime_run_entered", int'(streaming), 1);
        for (int i = 6; i <= 8; i++) push(10'(i));
        in_valid = 1'b0;
        wait_strobes(8, 100);
        chk("first_tick_latency", st_q[0] - run_start, 4);
        for (int i = 1; i < 8; i++) chk("pace_gap_div3", st_q[i] - st_q[i-1], 4);
        chk("no_underflow_after_8", int'(underflow_cnt), 0);
        enable = 1'b0;
        repeat (2) tick();

        // Full backpressure with stream disabled
        sc = strobe_cnt;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_data  = 10'h100 + 10'(acc);
            in_valid = 1'b1;
            rdy = in_ready;
            tick();
            if (rdy) begin
                exp_q.push_back(10'h100 + 10'(acc));
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("full_accepted", acc, 8);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_level", int'(level), 8);
        chk("full_D_held", int'(D), 8);
        chk("full_no_strobe", strobe_cnt, sc);

        // Drain at div=0, then underflow saturation and clear
        st_q.delete();
        div = 16'd0;
        enable = 1'b1;
        wait_strobes(sc + 8, 50);
        for (int i = 1; i < 8; i++) chk("pace_gap_div0", st_q[i] - st_q[i-1], 1);
        sc = strobe_cnt;
        repeat (300) tick();
        chk("uf_saturated", int'(underflow_cnt), 255);
        chk("uf_D_held", int'(D), 10'h107);
        chk("uf_no_strobe", strobe_cnt, sc);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("uf_cleared", int'(underflow_cnt), 0);
        tick();
        chk("uf_counts_again", int'(underflow_cnt), 1);

        // Simultaneous push/pop at level 2
        enable = 1'b0;
        repeat (2) tick();
        sc = strobe_cnt;
        for (int i = 0; i < 4; i++) push(10'h200 + 10'(i));
        in_valid = 1'b0;
        div = 16'd0;
        enable = 1'b1;
        wait_stream_level(2, 20);
        st_q.delete();
        for (int i = 0; i < 10; i++) begin
            push(10'h210 + 10'(i));
            chk("pushpop_level", int'(level), 2);
        end
        in_valid = 1'b0;
        wait_strobes(sc + 14, 30);
        for (int i = 1; i < st_q.size(); i++) chk("pushpop_gap", st_q[i] - st_q[i-1], 1);

        // Divider change mid-period, then disable
        enable = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) push(10'h300 + 10'(i));
        in_valid = 1'b0;
        chk("div_fill_level", int'(level), 8);
        sc = strobe_cnt;
        st_q.delete();
        div = 16'd9;
        enable = 1'b1;
        wait_strobes(sc + 1, 50);
        chk("div9_first_latency", st_q[0] - run_start, 10);
        repeat (3) tick();
        div = 16'd1;
        wait_strobes(sc + 4, 50);
        chk("div_change_gap_old", st_q[1] - st_q[0], 10);
        chk("div_change_gap_new1", st_q[2] - st_q[1], 2);
        chk("div_change_gap_new2", st_q[3] - st_q[2], 2);
        enable = 1'b0;
        tick();
        chk("disable_streaming", int'(streaming), 0);
        repeat (20) tick();
        chk("disable_no_strobe", strobe_cnt, sc + 4);
        chk("disable_fifo_kept", int'(level), 4);

        // Asynchronous reset mid-stream with level 5
        push(10'h3F0);
        in_valid = 1'b0;
        enable = 1'b1;
        wait_stream_level(5, 20);
        chk("pre_reset_uf_nonzero", (underflow_cnt != 0) ? 1 : 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_D", int'(D), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_streaming", int'(streaming), 0);
        chk("mid_rst_underflow", int'(underflow_cnt), 0);
        chk("mid_rst_strobe", int'(d_strobe), 0);
        exp_q.delete();
        enable = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
